io_input_debounce: RTL and testbench
====================================

// Module: io_input_debounce
// PURPOSE
//  Board-input conditioner sitting directly upstream of the data-memory I/O read port.
//  - Synchronises raw switches sw_raw[9:0] and active-low pushbuttons key_raw[3:1] into dmem_clk.
//  - Debounces them; sw_db/key_db drive the memory-mapped sw/key inputs read at 0xffffff00 / 0xffffff10.
//  - Also provides per-key press pulses and sticky press flags, clearable by CPU write strobes.
// PARAMETERS
//  DB_CNT   1000  dmem_clk cycles an input must hold a new value before it is committed (>=2)
//  CNT_W    10    counter width; DB_CNT <= 2**CNT_W - 1
// PORTS
//  dmem_clk    in   1   clock; all state on posedge
//  resetn      in   1   reset resetn, asynchronous, active-low
//  sw_raw      in   10  raw slide switches, asynchronous, 1 = on
//  key_raw     in   3   raw pushbuttons [3:1], asynchronous, 0 = pressed
//  sticky_clr  in   3   per-key clear of key_sticky, 1-cycle strobe from the I/O write decoder
//  sw_db       out  10  debounced switch vector
//  key_db      out  3   debounced key levels, 0 = pressed (same polarity as key_raw)
//  key_press   out  3   1-cycle pulse on debounced press (key_db 1->0)
//  key_sticky  out  3   set by key_press, held until sticky_clr
// BEHAVIOUR
//  Reset (async, resetn=0): sync flops sw=0 / key=1; sw_db=0; key_db=3'b111; key_press=0;
//   key_sticky=0; all counters=0. Outputs are registered and reach these values without a clock edge.
//  Synchroniser: 2-flop chain per bit; s2 is the synchronised value. s2 trails raw by 2 edges.
//  Key debounce: independent per key i, FSM {STABLE, PENDING}, counter kc[i].
//   - STABLE: if s2[i] != key_db[i], go to PENDING with kc=1; else kc=0.
//   - PENDING: if s2[i] == key_db[i], return to STABLE with kc=0 (glitch rejected).
//     Else, if kc == DB_CNT-1, commit key_db[i]<=s2[i], kc=0, go to STABLE.
//     Otherwise kc++.
//   - A level held continuously therefore commits exactly DB_CNT edges after s2 first differs.
//   - Total raw-to-key_db latency = DB_CNT+2 edges.
//  Switch debounce: one shared counter sc and a snapshot register sw_last.
//   - If s2_sw != sw_last: sw_last<=s2_sw, sc=0 (any bit change restarts the window).
//   - Else, if sw_last != sw_db: sc++. When sc == DB_CNT-1, commit sw_db<=sw_last and set sc=0.
//   - Else sc=0.
//   - sw_db updates all 10 bits in one cycle; never shows a partial vector.
//  key_press[i]: high exactly the cycle after key_db[i] commits 1->0; release (0->1) gives no pulse.
//  key_sticky[i]: set on key_press[i]; cleared on sticky_clr[i]. Set and clear in the same cycle: set wins.
//  No counter wraps: counters are cleared at commit, and DB_CNT <= 2**CNT_W-1 guarantees no overflow.
//  Reset mid-debounce: the pending change is discarded.
//   - An input still held after reset re-debounces from zero; no press pulse is generated during reset.
//  Bouncing input with no stable run of DB_CNT cycles: output never changes.
// TESTING (bench uses DB_CNT=4)
//  1 Reset: assert resetn=0 mid-clock ->
//    sw_db=0, key_db=3'b111, key_press=0, key_sticky=0 immediately.
//  2 Clean press: key_raw[1] 1->0 and held ->
//    key_db[1]=0 on the 6th edge; key_press[1]=1 for one cycle on the 7th; key_sticky[1]=1 stays set.
//  3 Bounce: key_raw[2] toggles 0,1,0,1 every 2 cycles, then holds 0 ->
//    no change until 4 stable synchronised cycles elapse; then a single key_press[2] pulse.
//  4 Switches: sw_raw 0->10'h155, bit 0 flips back for 1 cycle at cycle 2, then restored ->
//    sw_db stays 0 until 4 cycles after the last change, then becomes 10'h155 in one step.
//  5 Sticky: key_sticky[3]=1 and sticky_clr[3]=1 with a coincident key_press[3] -> key_sticky[3] stays 1.
//    Next sticky_clr[3] alone -> key_sticky[3]=0.
//  6 Reset mid-pending: key_raw[1]=0 held; pulse resetn low at kc=2 ->
//    after release, key_db[1] commits 6 edges later with one key_press[1].

Source files
------------

// File: rtl/io_input_debounce.sv
// Board switch/key conditioner for the data-memory I/O read port: 2-flop sync,
// debounce, key press pulses and CPU-clearable sticky press flags.

module io_key_db #(
   parameter int unsigned DB_CNT = 1000,
   parameter int unsigned CNT_W  = 10
) (
   input  logic dmem_clk,
   input  logic resetn,
   input  logic s2,
   input  logic sticky_clr,
   output logic key_db,
   output logic key_press,
   output logic key_sticky
);

   typedef enum logic {STABLE, PENDING} db_state_e;

   db_state_e        state, state_n;
   logic [CNT_W-1:0] kc, kc_n;
   logic             db_n;
   logic             key_db_q;

   always_ff @(posedge dmem_clk or negedge resetn) begin
      if (!resetn) begin
         state      <= STABLE;
         kc         <= '0;
         key_db     <= 1'b1;
         key_db_q   <= 1'b1;
         key_press  <= 1'b0;
         key_sticky <= 1'b0;
      end else begin
         state      <= state_n;
         kc         <= kc_n;
         key_db     <= db_n;
         key_db_q   <= key_db;
         key_press  <= key_db_q & ~key_db;
         // a press landing in the same cycle as a clear must not be lost
         key_sticky <= (key_sticky & ~sticky_clr) | key_press;
      end
   end

   always_comb begin
      state_n = state;
      kc_n    = kc;
      db_n    = key_db;
      case (state)
         STABLE: begin
            if (s2 != key_db) begin
               state_n = PENDING;
               kc_n    = CNT_W'(1);
            end else begin
               kc_n    = '0;
            end
         end
         PENDING: begin
            if (s2 == key_db) begin
               state_n = STABLE;
               kc_n    = '0;
            end else if (kc == CNT_W'(DB_CNT - 1)) begin
               db_n    = s2;
               kc_n    = '0;
               state_n = STABLE;
            end else begin
               kc_n    = kc + CNT_W'(1);
            end
         end
         default: begin
            state_n = STABLE;
            kc_n    = '0;
         end
      endcase
   end

endmodule

module io_input_debounce #(
   parameter int unsigned DB_CNT = 1000,
   parameter int unsigned CNT_W  = 10
) (
   input  logic        dmem_clk,
   input  logic        resetn,
   input  logic [9:0]  sw_raw,
   input  logic [3:1]  key_raw,
   input  logic [3:1]  sticky_clr,
   output logic [9:0]  sw_db,
   output logic [3:1]  key_db,
   output logic [3:1]  key_press,
   output logic [3:1]  key_sticky
);

   logic [9:0]       sw_s1, sw_s2, sw_last;
   logic [3:1]       key_s1, key_s2;
   logic [CNT_W-1:0] sc;

   always_ff @(posedge dmem_clk or negedge resetn) begin
      if (!resetn) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         key_s1 <= '1;
         key_s2 <= '1;
      end else begin
         sw_s1  <= sw_raw;
         sw_s2  <= sw_s1;
         key_s1 <= key_raw;
         key_s2 <= key_s1;
      end
   end

   // One shared window for all switches so sw_db only ever moves as a whole vector
   always_ff @(posedge dmem_clk or negedge resetn) begin
      if (!resetn) begin
         sw_last <= '0;
         sw_db   <= '0;
         sc      <= '0;
      end else if (sw_s2 != sw_last) begin
         sw_last <= sw_s2;
         sc      <= '0;
      end else if (sw_last != sw_db) begin
         if (sc == CNT_W'(DB_CNT - 1)) begin
            sw_db <= sw_last;
            sc    <= '0;
         end else begin
            sc    <= sc + CNT_W'(1);
         end
      end else begin
         sc <= '0;
      end
   end

   for (genvar i = 1; i <= 3; i++) begin : g_key
      io_key_db #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) u_key (
         .dmem_clk   (dmem_clk),
         .resetn     (resetn),
         .s2         (key_s2[i]),
         .sticky_clr (sticky_clr[i]),
         .key_db     (key_db[i]),
         .key_press  (key_press[i]),
         .key_sticky (key_sticky[i])
      );
   end

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce with DB_CNT=4; expected edge counts are hand-derived.

module tb_io_input_debounce;

   logic       dmem_clk;
   logic       resetn;
   logic [9:0] sw_raw;
   logic [3:1] key_raw;
   logic [3:1] sticky_clr;
   logic [9:0] sw_db;
   logic [3:1] key_db;
   logic [3:1] key_press;
   logic [3:1] key_sticky;

   int checks = 0;
   int errors = 0;

   io_input_debounce #(.DB_CNT(4), .CNT_W(3)) dut (
      .dmem_clk   (dmem_clk),
      .resetn     (resetn),
      .sw_raw     (sw_raw),
      .key_raw    (key_raw),
      .sticky_clr (sticky_clr),
      .sw_db      (sw_db),
      .key_db     (key_db),
      .key_press  (key_press),
      .key_sticky (key_sticky)
   );

   initial dmem_clk = 1'b0;
   always #5 dmem_clk = ~dmem_clk;

   task automatic tick();
      @(posedge dmem_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " sw_db"},      32'(sw_db),      32'h0);
      chk({tag, " key_db"},     32'(key_db),     32'h7);
      chk({tag, " key_press"},  32'(key_press),  32'h0);
      chk({tag, " key_sticky"}, 32'(key_sticky), 32'h0);
   endtask

   initial begin
      resetn     = 1'b1;
      sw_raw     = '0;
      key_raw    = 3'b111;
      sticky_clr = '0;

      // 1: async reset mid-clock, outputs valid before any edge
      tick();
      tick();
      #2 resetn = 1'b0;
      #1 chk_reset_state("rst_async");
      tick();
      resetn = 1'b1;

      // 2: clean press on key 1
      key_raw = 3'b110;
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk("press1 key_db hold", 32'(key_db), 32'h7);
      end
      tick();
      chk("press1 key_db commit", 32'(key_db), 32'h6);
      chk("press1 no early pulse", 32'(key_press), 32'h0);
      tick();
      chk("press1 pulse", 32'(key_press), 32'h1);
      chk("press1 sticky before", 32'(key_sticky), 32'h0);
      tick();
      chk("press1 pulse end", 32'(key_press), 32'h0);
      chk("press1 sticky set", 32'(key_sticky), 32'h1);
      tick();
      chk("press1 sticky held", 32'(key_sticky), 32'h1);

      // 3: key 2 bounces 0,1,0,1 for two cycles each, then holds 0
      for (int e = 1; e <= 13; e++) begin
         key_raw[2] = (e == 3 || e == 4 || e == 7 || e == 8) ? 1'b1 : 1'b0;
         tick();
         chk("bounce key_db2 hold", 32'(key_db[2]), 32'h1);
         chk("bounce no pulse", 32'(key_press[2]), 32'h0);
      end
      tick();
      chk("bounce key_db commit", 32'(key_db), 32'h4);
      tick();
      chk("bounce pulse", 32'(key_press), 32'h2);
      tick();
      chk("bounce pulse end", 32'(key_press), 32'h0);
      chk("bounce sticky", 32'(key_sticky), 32'h3);

      // release of key 2 commits but gives no pulse
      key_raw[2] = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk("release key_db2 hold", 32'(key_db[2]), 32'h0);
         chk("release no pulse", 32'(key_press), 32'h0);
      end
      tick();
      chk("release key_db2", 32'(key_db[2]), 32'h1);
      for (int e = 1; e <= 2; e++) begin
         tick();
         chk("release no pulse after", 32'(key_press), 32'h0);
      end

      // 4: switches with a one-cycle glitch on bit 0
      sw_raw = 10'h155;
      tick();
      sw_raw = 10'h154;
      tick();
      sw_raw = 10'h155;
      for (int e = 3; e <= 8; e++) begin
         tick();
         chk("sw hold", 32'(sw_db), 32'h0);
      end
      tick();
      chk("sw commit", 32'(sw_db), 32'h155);

      // 5: sticky set wins over a coincident clear, plain clear afterwards
      key_raw[3] = 1'b0;
      for (int e = 1; e <= 6; e++) tick();
      chk("key3 commit", 32'(key_db[3]), 32'h0);
      tick();
      chk("key3 pulse", 32'(key_press), 32'h4);
      sticky_clr = 3'b100;
      tick();
      sticky_clr = 3'b000;
      chk("sticky set wins", 32'(key_sticky[3]), 32'h1);
      tick();
      chk("sticky3 held", 32'(key_sticky[3]), 32'h1);
      sticky_clr = 3'b100;
      tick();
      sticky_clr = 3'b000;
      chk("sticky3 cleared", 32'(key_sticky), 32'h3);

      // 6: reset, then reset again while key 1 is pending at kc=2
      #2 resetn = 1'b0;
      #1 chk_reset_state("rst_mid");
      tick();
      resetn = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk("pend key_db1 hold", 32'(key_db[1]), 32'h1);
      end
      #2 resetn = 1'b0;
      #1 chk_reset_state("rst_pending");
      resetn = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk("repend key_db1 hold", 32'(key_db[1]), 32'h1);
         chk("repend no pulse", 32'(key_press[1]), 32'h0);
      end
      tick();
      chk("repend key_db1 commit", 32'(key_db[1]), 32'h0);
      tick();
      chk("repend pulse", 32'(key_press[1]), 32'h1);
      tick();
      chk("repend pulse end", 32'(key_press[1]), 32'h0);
      chk("repend sticky", 32'(key_sticky[1]), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
